// File: rtl/imem_ctrl_pkg.sv
// Shared types, constants and helpers for the instruction-memory access controller.
package imem_ctrl_pkg;

  typedef enum logic [1:0] {
    StLoad,
    StRun,
    StDrain
  } ctrl_state_e;

  localparam logic [31:0] NopInstr = 32'h00000013;

  // A fetch PC is unusable if it is not word aligned or points past the array.
  function automatic logic pc_bad(input logic [31:0] pc, input int unsigned addr_w);
    logic [31:0] hi;
    hi = pc >> (addr_w + 2);
    return (pc[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

endpackage

// File: rtl/imem_rd_pipe.sv
// One-deep read return stage: tracks the outstanding fetch and muxes NOP when
// no valid read data is being presented.
module imem_rd_pipe
  import imem_ctrl_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NopInstr
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue,
  input  logic        flush,
  input  logic [31:0] rdata,
  output logic        rvalid,
  output logic [31:0] instr
);

  logic pending_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= issue;
    end
  end

  always_comb begin
    rvalid = pending_q && !flush;
    instr  = rvalid ? rdata : NOP_INSTR;
  end

endmodule

// File: rtl/imem_access_ctrl.sv
// Arbitrates the single instruction-memory port between the boot loader (writes)
// and the fetch stage (reads), with load / run / drain phases.
module imem_access_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 6,
  parameter logic [31:0] NOP_INSTR = NopInstr
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              boot_done,
  output logic [ADDR_W:0]   ld_count,
  input  logic              fe_req,
  input  logic [31:0]       fe_pc,
  input  logic              fe_flush,
  output logic              fe_gnt,
  output logic              fe_rvalid,
  output logic [31:0]       fe_instr,
  output logic              fe_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [ADDR_W:0] CntMax = {1'b1, {ADDR_W{1'b0}}};

  ctrl_state_e     state_q, state_d;
  logic [ADDR_W:0] ld_count_q, ld_count_d;
  logic            boot_done_q, boot_done_d;
  logic            fe_err_q, fe_err_d;
  logic            pc_is_bad;

  assign pc_is_bad = pc_bad(fe_pc, ADDR_W);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StLoad;
      ld_count_q  <= '0;
      boot_done_q <= 1'b0;
      fe_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_count_q  <= ld_count_d;
      boot_done_q <= boot_done_d;
      fe_err_q    <= fe_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    ld_count_d  = ld_count_q;
    boot_done_d = boot_done_q;
    fe_err_d    = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (ld_valid) begin
          if (ld_count_q != CntMax) ld_count_d = ld_count_q + 1'b1;
          if (ld_last) begin
            state_d     = StRun;
            boot_done_d = 1'b1;
          end
        end
      end
      StRun: begin
        fe_err_d = fe_req && pc_is_bad && !fe_flush;
        if (ld_valid) state_d = StDrain;
      end
      StDrain: begin
        state_d     = StLoad;
        ld_count_d  = '0;
        boot_done_d = 1'b0;
      end
      default: state_d = StLoad;
    endcase
  end

  // Output logic; loader wins the port over any simultaneous fetch in RUN.
  always_comb begin
    ld_ready  = 1'b0;
    fe_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      StLoad: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = ld_addr;
          mem_wdata = ld_data;
        end
      end
      StRun: begin
        fe_gnt = fe_req && !pc_is_bad && !fe_flush && !ld_valid;
        if (fe_gnt) begin
          mem_en   = 1'b1;
          mem_addr = fe_pc[ADDR_W+1:2];
        end
      end
      default: ;
    endcase
  end

  assign ld_count  = ld_count_q;
  assign boot_done = boot_done_q;
  assign fe_err    = fe_err_q;

  imem_rd_pipe #(
    .NOP_INSTR(NOP_INSTR)
  ) u_rd_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .issue (fe_gnt),
    .flush (fe_flush),
    .rdata (mem_rdata),
    .rvalid(fe_rvalid),
    .instr (fe_instr)
  );

endmodule
